// File: rtl/mux_scan_pkg.sv
// Shared constants and state type for the mux scan controller.
package mux_scan_pkg;

  localparam int unsigned NUM_CH    = 6;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DWELL_MAX = 15;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux select/return path and result handshake bundle.
// The master side is the scan controller; the slave side is its parent
// (start/data_ready source and the 6:1 mux feeding mux_in).
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              mux_in;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic [NUM_CH-1:0] data;
  logic              data_valid;
  logic              data_ready;

  modport master (
    input  start, mux_in, data_ready,
    output sel, busy, data, data_valid
  );

  modport slave (
    output start, mux_in, data_ready,
    input  sel, busy, data, data_valid
  );

endinterface

// File: rtl/mux_scan_ctrl.sv
// Mux scan controller: steps an external 6:1 mux through channels 0..5,
// holding each select for DWELL cycles and sampling mux_in on the last
// dwell cycle, then presents the assembled word with a valid/ready handshake.
// Optional macro MUX_SCAN_CONT_EN: a completed handshake restarts the scan
// immediately instead of returning to IDLE.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [NUM_CH-1:0] data_q, data_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Select, dwell counter and result word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      sel_q  <= sel_nxt;
      cnt_q  <= cnt_nxt;
      data_q <= data_nxt;
    end
  end

  // Next-state, select stepping and per-channel sampling.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SCAN;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_nxt = '0;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sel_q == SEL_W'(k)) data_nxt[k] = bus.mux_in;
          end
          if (sel_q == SEL_LAST) begin
            state_nxt = HOLD;
            sel_nxt   = '0;
          end else begin
            sel_nxt = sel_q + 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.data_ready) begin
`ifdef MUX_SCAN_CONT_EN
          state_nxt = SCAN;
`else
          state_nxt = IDLE;
`endif
          sel_nxt = '0;
          cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sel        = sel_q;
  assign bus.data       = data_q;
  assign bus.busy       = (state != IDLE);
  assign bus.data_valid = (state == HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: one instance with DWELL=1 and one
// with DWELL=3, each driven by a behavioural 6:1 mux model. Expected words
// are queued when a scan is launched and compared at each handshake.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst;
  logic [5:0] in_a;
  logic [5:0] in_b;
  int checks;
  int errors;
  logic [5:0] exp_a[$];
  logic [5:0] exp_b[$];

  mux_scan_ctrl_if if_a();
  mux_scan_ctrl_if if_b();

  mux_scan_ctrl u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mux_scan_ctrl #(.DWELL(3)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // Behavioural 6:1 mux models.
  assign if_a.mux_in = (if_a.sel < 3'd6) ? in_a[if_a.sel] : 1'b0;
  assign if_b.mux_in = (if_b.sel < 3'd6) ? in_b[if_b.sel] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [5:0] w);
    in_a = w;
    exp_a.push_back(w);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
  endtask

  // Scoreboard and select-range monitors.
  always @(negedge clk) begin
    check("a_sel_range", (if_a.sel < 3'd6), 1'b1);
    if (!rst && if_a.data_valid && if_a.data_ready) begin
      check("a_sb_nonempty", (exp_a.size() != 0), 1'b1);
      if (exp_a.size() != 0) check("a_data", if_a.data, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    check("b_sel_range", (if_b.sel < 3'd6), 1'b1);
    if (!rst && if_b.data_valid && if_b.data_ready) begin
      check("b_sb_nonempty", (exp_b.size() != 0), 1'b1);
      if (exp_b.size() != 0) check("b_data", if_b.data, exp_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    in_a = '0;
    in_b = '0;
    if_a.start = 1'b0; if_a.data_ready = 1'b0;
    if_b.start = 1'b0; if_b.data_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_sel", if_a.sel, 0);
    check("rst_busy", if_a.busy, 0);
    check("rst_data", if_a.data, 0);
    check("rst_valid", if_a.data_valid, 0);
    check("rst_b_busy", if_b.busy, 0);
    tick();

    // DWELL=3: each select held three cycles, 18 scan cycles.
    in_b = 6'b010011;
    exp_b.push_back(in_b);
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("d3_sel", if_b.sel, k / 3);
      check("d3_valid_lo", if_b.data_valid, 0);
      tick();
    end
    @(negedge clk);
    check("d3_valid", if_b.data_valid, 1);
    check("d3_data", if_b.data, 6'b010011);
    tick();
    if_b.data_ready = 1'b1;
    @(negedge clk);
    tick();
    if_b.data_ready = 1'b0;

    // DWELL=1 basic scan and latency.
    start_a(6'b101101);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("s1_sel", if_a.sel, k);
      check("s1_valid_lo", if_a.data_valid, 0);
      check("s1_busy", if_a.busy, 1);
      tick();
    end
    @(negedge clk);
    check("s1_valid", if_a.data_valid, 1);
    check("s1_data", if_a.data, 6'b101101);
    check("s1_hold_sel", if_a.sel, 0);
    check("s1_hold_busy", if_a.busy, 1);
    tick();

`ifdef MUX_SCAN_CONT_EN
    // Back-to-back scans with data_ready held high, no further start.
    in_a = 6'b000001;
    for (int k = 0; k < 3; k++) exp_a.push_back(6'b000001);
    if_a.data_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      check("cont_valid", if_a.data_valid, (c % 7 == 0));
      tick();
    end
    if_a.data_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    // Backpressure: result stable while data_ready is low.
    in_a = 6'b111111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_data", if_a.data, 6'b101101);
      check("bp_valid", if_a.data_valid, 1);
      tick();
    end
    if_a.data_ready = 1'b1;
    @(negedge clk);
    tick();
    if_a.data_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_valid", if_a.data_valid, 0);
    check("bp_idle_busy", if_a.busy, 0);
    check("bp_retained", if_a.data, 6'b101101);
    tick();

    // start during SCAN/HOLD and data_ready during SCAN are ignored.
    start_a(6'b010110);
    if_a.data_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ign_sel", if_a.sel, k);
      tick();
      if_a.start = (k == 1);
      if_a.data_ready = (k < 2);
    end
    @(negedge clk);
    check("ign_valid", if_a.data_valid, 1);
    check("ign_data", if_a.data, 6'b010110);
    tick();
    if_a.start = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("hold_start_sel", if_a.sel, 0);
    check("hold_start_valid", if_a.data_valid, 1);
    tick();
    if_a.data_ready = 1'b1;
    @(negedge clk);
    tick();
    if_a.start = 1'b0;
    if_a.data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_queue_busy", if_a.busy, 0);
      check("no_queue_valid", if_a.data_valid, 0);
      tick();
    end

    // Reset mid-scan at sel==3.
    start_a(6'b111000);
    n = 0;
    @(negedge clk);
    while (if_a.sel != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_sel3", if_a.sel, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_a.delete();
    @(negedge clk);
    check("mid_rst_busy", if_a.busy, 0);
    check("mid_rst_sel", if_a.sel, 0);
    check("mid_rst_data", if_a.data, 0);
    check("mid_rst_valid", if_a.data_valid, 0);
    tick();

    // rst dominates start.
    rst = 1'b1;
    if_a.start = 1'b1;
    tick();
    rst = 1'b0;
    if_a.start = 1'b0;
    @(negedge clk);
    check("rst_dom_busy", if_a.busy, 0);
    tick();

    // Normal scan after reset.
    start_a(6'b011011);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_sel", if_a.sel, k);
      tick();
    end
    @(negedge clk);
    check("post_valid", if_a.data_valid, 1);
    check("post_data", if_a.data, 6'b011011);
    tick();
    if_a.data_ready = 1'b1;
    @(negedge clk);
    tick();
    if_a.data_ready = 1'b0;
`endif

    @(negedge clk);
    check("sb_left", exp_a.size() + exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
